// File: rtl/read_capture_queue.sv
// DFI read-data capture: realigns half-word-offset returns, drops dummy reads, buffers words in a FWFT FIFO.
// Optional saturating statistics counters are enabled by defining RDCAP_STATS_EN.
module read_capture_queue #(
  parameter  int DQ_WIDTH    = 64,
  parameter  int NCK_PER_CLK = 2,
  parameter  int FIFO_DEPTH  = 8,
  parameter  int CNT_WIDTH   = 16,
  localparam int W           = 2 * NCK_PER_CLK * DQ_WIDTH,
  localparam int PW          = $clog2(FIFO_DEPTH),
  localparam int LW          = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         dfi_rddata,
  input  logic                 dfi_rddata_valid,
  input  logic                 dfi_rddata_valid_even,
  input  logic                 dfi_rddata_valid_odd,
  input  logic                 clr_overflow,
  output logic                 rdq_valid,
  output logic [W-1:0]         rdq_data,
  input  logic                 rdq_ready,
  output logic [LW-1:0]        rdq_level,
  output logic                 rdq_overflow,
  output logic [CNT_WIDTH-1:0] dummy_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  logic [W-1:0]  d_r;
  logic [W-1:0]  d_r2;
  logic          v_r;
  logic          e_r;
  logic          o_r;

  logic          cap;
  logic          dummy;
  logic [W-1:0]  cap_word;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_r  <= '0;
      d_r2 <= '0;
      v_r  <= 1'b0;
      e_r  <= 1'b0;
      o_r  <= 1'b0;
    end else begin
      d_r  <= dfi_rddata;
      d_r2 <= d_r;
      v_r  <= dfi_rddata_valid;
      e_r  <= dfi_rddata_valid_even;
      o_r  <= dfi_rddata_valid_odd;
    end
  end

  // Dummy reads win over the even qualifier; e_r only matters once cap is set.
  assign cap      = v_r & ~o_r;
  assign dummy    = v_r & o_r;
  assign cap_word = e_r ? {d_r[W/2-1:0], d_r2[W-1:W/2]} : d_r;

  assign full      = (level == LW'(FIFO_DEPTH));
  assign rdq_valid = (level != '0);
  assign pop       = rdq_valid & rdq_ready;
  // A same-cycle pop frees the slot, so a full FIFO can still accept.
  assign push      = cap & (~full | pop);
  assign drop      = cap & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= cap_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  assign rdq_data     = mem[rd_ptr];
  assign rdq_level    = level;
  assign rdq_overflow = overflow;

`ifdef RDCAP_STATS_EN
  logic [CNT_WIDTH-1:0] dummy_q;
  logic [CNT_WIDTH-1:0] drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dummy_q <= '0;
      drop_q  <= '0;
    end else begin
      if (dummy && (dummy_q != '1)) dummy_q <= dummy_q + 1'b1;
      if (drop  && (drop_q  != '1)) drop_q  <= drop_q + 1'b1;
    end
  end

  assign dummy_cnt = dummy_q;
  assign drop_cnt  = drop_q;
`else
  assign dummy_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_read_capture_queue.sv
// Randomised and directed bench for read_capture_queue against a queue-based reference model.
module tb_read_capture_queue;
  localparam int DQ    = 64;
  localparam int NCK   = 2;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int W     = 2 * NCK * DQ;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  dfi_rddata;
  logic          dfi_rddata_valid;
  logic          dfi_rddata_valid_even;
  logic          dfi_rddata_valid_odd;
  logic          clr_overflow;
  logic          rdq_valid;
  logic [W-1:0]  rdq_data;
  logic          rdq_ready;
  logic [LW-1:0] rdq_level;
  logic          rdq_overflow;
  logic [CW-1:0] dummy_cnt;
  logic [CW-1:0] drop_cnt;

  read_capture_queue #(
    .DQ_WIDTH(DQ), .NCK_PER_CLK(NCK), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .dfi_rddata(dfi_rddata),
    .dfi_rddata_valid(dfi_rddata_valid),
    .dfi_rddata_valid_even(dfi_rddata_valid_even),
    .dfi_rddata_valid_odd(dfi_rddata_valid_odd),
    .clr_overflow(clr_overflow),
    .rdq_valid(rdq_valid), .rdq_data(rdq_data), .rdq_ready(rdq_ready),
    .rdq_level(rdq_level), .rdq_overflow(rdq_overflow),
    .dummy_cnt(dummy_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the word queue plus what the DUT saw one and two cycles back.
  logic [W-1:0] q[$];
  logic [W-1:0] m_d1, m_d2;
  logic         m_v1, m_e1, m_o1;
  logic         m_ovf;
  int           m_dummy, m_drop;
  localparam int CMAX = (1 << CW) - 1;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_d1 = '0; m_d2 = '0; m_v1 = 0; m_e1 = 0; m_o1 = 0;
    m_ovf = 0; m_dummy = 0; m_drop = 0;
  endtask

  task automatic check_all();
    check_eq("rdq_valid", W'(rdq_valid), W'(q.size() != 0));
    check_eq("rdq_level", W'(rdq_level), W'(q.size()));
    check_eq("rdq_overflow", W'(rdq_overflow), W'(m_ovf));
    if (q.size() != 0) check_eq("rdq_data", rdq_data, q[0]);
`ifdef RDCAP_STATS_EN
    check_eq("dummy_cnt", W'(dummy_cnt), W'(m_dummy));
    check_eq("drop_cnt", W'(drop_cnt), W'(m_drop));
`else
    check_eq("dummy_cnt", W'(dummy_cnt), '0);
    check_eq("drop_cnt", W'(drop_cnt), '0);
`endif
  endtask

  // One clock: present inputs, advance the model across the edge, then compare.
  task automatic cyc(input logic v, input logic e, input logic o, input logic [W-1:0] d,
                     input logic rdy, input logic clr);
    logic         pop, cap, drp;
    logic [W-1:0] wd;
    dfi_rddata = d; dfi_rddata_valid = v; dfi_rddata_valid_even = e;
    dfi_rddata_valid_odd = o; rdq_ready = rdy; clr_overflow = clr;
    pop = (q.size() != 0) && rdy;
    cap = m_v1 && !m_o1;
    wd  = m_e1 ? {m_d1[W/2-1:0], m_d2[W-1:W/2]} : m_d1;
    drp = cap && (q.size() == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (cap && !drp) q.push_back(wd);
    if (drp) begin
      m_ovf = 1;
      if (m_drop < CMAX) m_drop++;
    end else if (clr) m_ovf = 0;
    if (m_v1 && m_o1 && m_dummy < CMAX) m_dummy++;
    m_d2 = m_d1; m_d1 = d; m_v1 = v; m_e1 = e; m_o1 = o;
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [W-1:0] rword();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle(input int n, input logic rdy);
    repeat (n) cyc(0, 0, 0, '0, rdy, 0);
  endtask

  logic [W-1:0] wa, wb, wc, wp, wq, wx;

  initial begin
    rst = 1; dfi_rddata = '0; dfi_rddata_valid = 0; dfi_rddata_valid_even = 0;
    dfi_rddata_valid_odd = 0; clr_overflow = 0; rdq_ready = 0;
    model_reset();
    #12;
    check_eq("reset_valid", W'(rdq_valid), '0);
    check_eq("reset_data", rdq_data, '0);
    check_all();
    #4 rst = 0;

    // In-order streaming with a ready consumer.
    wa = rword(); wb = rword(); wc = rword();
    cyc(1, 0, 0, wa, 1, 0);
    check_eq("lat_not_yet", W'(rdq_valid), '0);
    cyc(1, 0, 0, wb, 1, 0);
    check_eq("lat_a_out", rdq_data, wa);
    cyc(1, 0, 0, wc, 1, 0);
    check_eq("b_out", rdq_data, wb);
    idle(3, 1);

    // Half-word realignment.
    wp = rword(); wq = rword();
    cyc(0, 0, 0, wp, 0, 0);
    cyc(1, 1, 0, wq, 0, 0);
    cyc(0, 0, 0, '0, 0, 0);
    check_eq("realign", rdq_data, {wq[W/2-1:0], wp[W-1:W/2]});
    idle(2, 1);

    // Dummy read with even also set.
    cyc(1, 1, 1, rword(), 1, 0);
    idle(2, 1);
    check_eq("dummy_level", W'(rdq_level), '0);

    // Overflow with 10 words into 8 entries.
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, rword(), 0, 0);
    idle(2, 0);
    check_eq("ovf_level", W'(rdq_level), W'(DEPTH));
    check_eq("ovf_flag", W'(rdq_overflow), W'(1));
`ifdef RDCAP_STATS_EN
    check_eq("ovf_drop_cnt", W'(drop_cnt), W'(2));
`endif
    idle(DEPTH + 1, 1);
    cyc(0, 0, 0, '0, 0, 1);

    // Push into a full FIFO while popping: no drop.
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, rword(), 0, 0);
    wx = rword();
    cyc(1, 0, 0, wx, 0, 0);
    cyc(0, 0, 0, '0, 1, 0);
    check_eq("full_pp_level", W'(rdq_level), W'(DEPTH));
    check_eq("full_pp_ovf", W'(rdq_overflow), '0);
    idle(DEPTH - 1, 1);
    check_eq("full_pp_last", rdq_data, wx);
    idle(2, 1);

    // Asynchronous reset between edges with the FIFO half full.
    for (int i = 0; i < DEPTH / 2; i++) cyc(1, 0, 0, rword(), 0, 0);
    cyc(0, 0, 0, '0, 0, 0);
    dfi_rddata_valid = 0;
    #3 rst = 1;
    #1;
    check_eq("arst_valid", W'(rdq_valid), '0);
    check_eq("arst_level", W'(rdq_level), '0);
    model_reset();
    #2 rst = 0;
    wa = rword();
    cyc(1, 0, 0, wa, 0, 0);
    check_eq("arst_lat1", W'(rdq_valid), '0);
    cyc(0, 0, 0, '0, 0, 0);
    check_eq("arst_lat2", rdq_data, wa);
    idle(2, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
          rword(), $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    end
    idle(DEPTH + 3, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
